// File: rtl/ltl_mon_pkg.sv
// rtl/ltl_mon_pkg.sv - shared types for the LTL monitor symbol interface
// Contents:
//   SYMBOL_W    width of one monitor symbol
//   symbol_t    one monitor symbol
//   enc_state_e encoder sequencing state (monitor held in reset / streaming)
package ltl_mon_pkg;

    localparam int SYMBOL_W = 8;

    typedef logic [SYMBOL_W-1:0] symbol_t;

    typedef enum logic {
        MON_RST = 1'b0,
        STREAM  = 1'b1
    } enc_state_e;

endpackage

// File: rtl/ltl_sym_fifo.sv
// rtl/ltl_sym_fifo.sv - DEPTH x symbol synchronous FIFO with sync clear
// Ports:
//   clk_i    clock
//   rst_ni   async active-low reset (pointers only)
//   clr_i    sync clear of both pointers; wins over push and pop
//   push_i   write wdata_i (ignored when full)
//   wdata_i  symbol to write
//   pop_i    advance read pointer (ignored when empty)
//   rdata_o  head-of-queue symbol (combinational read)
//   full_o   FIFO holds DEPTH entries
//   empty_o  FIFO holds no entries
//   count_o  current occupancy 0..DEPTH
module ltl_sym_fifo
    import ltl_mon_pkg::*;
#(
    parameter  int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          clr_i,
    input  logic          push_i,
    input  symbol_t       wdata_i,
    input  logic          pop_i,
    output symbol_t       rdata_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [AW:0]   count_o
);

    symbol_t       mem_q [DEPTH];
    logic [AW:0]   wptr_q, wptr_d;
    logic [AW:0]   rptr_q, rptr_d;
    logic          do_push;
    logic          do_pop;

    // Pointers carry one extra wrap bit: equal pointers mean empty, equal
    // index bits with differing wrap bits mean full.
    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = (wptr_q[AW] != rptr_q[AW]) &&
                     (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign count_o = wptr_q - rptr_q;
    assign rdata_o = mem_q[rptr_q[AW-1:0]];

    assign do_push = push_i && !full_o && !clr_i;
    assign do_pop  = pop_i && !empty_o && !clr_i;

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (clr_i) begin
            wptr_d = '0;
            rptr_d = '0;
        end else begin
            if (do_push) wptr_d = wptr_q + 1'b1;
            if (do_pop)  rptr_d = rptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    // Storage needs no reset: entries are only read once written.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/ltl_symbol_encoder.sv
// rtl/ltl_symbol_encoder.sv - packs proposition vectors into monitor symbols and sequences monitor reset
// Ports:
//   clk_i         clock
//   rst_ni        async active-low reset
//   flush_i       drop buffered symbols and restart the monitor
//   prop_valid_i  proposition vector valid
//   prop_i        atomic-proposition vector
//   prop_ready_o  encoder can accept prop_i (combinational from registered state)
//   symbols_o     symbol to the monitor
//   run_o         monitor steps on symbols_o this cycle
//   mon_reset_o   active-high synchronous reset to the monitor
//   drop_cnt_o    saturating count of dropped events
//   busy_o        FIFO non-empty or monitor still held in reset
module ltl_symbol_encoder
    import ltl_mon_pkg::*;
#(
    parameter int NPROP        = 8,
    parameter int DEPTH        = 8,
    parameter int RST_CYCLES   = 2,
    parameter int DROP_ON_FULL = 0,
    parameter int DROP_W       = 16
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              flush_i,
    input  logic              prop_valid_i,
    input  logic [NPROP-1:0]  prop_i,
    output logic              prop_ready_o,
    output logic [7:0]        symbols_o,
    output logic              run_o,
    output logic              mon_reset_o,
    output logic [DROP_W-1:0] drop_cnt_o,
    output logic              busy_o
);

    localparam int AW    = $clog2(DEPTH);
    // Counter only ever holds RST_CYCLES-1 down to 0.
    localparam int CNT_W = $clog2(RST_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RST_CYCLES - 1);

    enc_state_e        state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              mon_reset_q;
    logic              run_q;
    symbol_t           sym_q;
    logic              busy_q;
    logic [DROP_W-1:0] drop_q, drop_d;

    symbol_t           fifo_rdata;
    logic              fifo_full;
    logic              fifo_empty;
    logic [AW:0]       fifo_cnt;
    logic [AW:0]       fifo_cnt_nxt;

    logic              in_stream;
    logic              push;
    logic              pop;
    logic              drop_evt;
    symbol_t           push_sym;

    assign in_stream = (state_q == STREAM);

    assign prop_ready_o = (DROP_ON_FULL != 0) ? 1'b1 : (!fifo_full && in_stream);

    // Fullness is taken before any same-cycle pop, so a full FIFO refuses
    // the push even while it is being drained.
    assign push = prop_valid_i && prop_ready_o && in_stream && !fifo_full && !flush_i;
    assign pop  = in_stream && !fifo_empty && !flush_i;

    // Only in drop mode can an offered event be lost; in backpressure mode
    // the producer keeps it until prop_ready_o allows it in.
    assign drop_evt = (DROP_ON_FULL != 0) && prop_valid_i &&
                      (flush_i || !in_stream || fifo_full);

    assign push_sym = SYMBOL_W'(prop_i);

    // Occupancy after this edge, used to register busy_o without a cycle lag.
    assign fifo_cnt_nxt = fifo_cnt + (AW + 1)'(push) - (AW + 1)'(pop);

    ltl_sym_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clr_i   (flush_i),
        .push_i  (push),
        .wdata_i (push_sym),
        .pop_i   (pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_cnt)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= MON_RST;
            cnt_q       <= CNT_LOAD;
            mon_reset_q <= 1'b1;
            run_q       <= 1'b0;
            sym_q       <= '0;
            busy_q      <= 1'b1;
        end else if (flush_i) begin
            // symbols_o keeps its last value; only run_o qualifies it.
            state_q     <= MON_RST;
            cnt_q       <= CNT_LOAD;
            mon_reset_q <= 1'b1;
            run_q       <= 1'b0;
            busy_q      <= 1'b1;
        end else begin
            case (state_q)
                MON_RST: begin
                    run_q <= 1'b0;
                    if (cnt_q == '0) begin
                        state_q     <= STREAM;
                        mon_reset_q <= 1'b0;
                        busy_q      <= (fifo_cnt_nxt != '0);
                    end else begin
                        cnt_q  <= cnt_q - 1'b1;
                        busy_q <= 1'b1;
                    end
                end
                STREAM: begin
                    mon_reset_q <= 1'b0;
                    run_q       <= pop;
                    if (pop) sym_q <= fifo_rdata;
                    busy_q      <= (fifo_cnt_nxt != '0);
                end
                default: begin
                    state_q     <= MON_RST;
                    cnt_q       <= CNT_LOAD;
                    mon_reset_q <= 1'b1;
                    run_q       <= 1'b0;
                    busy_q      <= 1'b1;
                end
            endcase
        end
    end

    // Drop counter survives flush; only rst_ni clears it.
    always_comb begin
        drop_d = drop_q;
        if (drop_evt && (drop_q != {DROP_W{1'b1}})) drop_d = drop_q + 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) drop_q <= '0;
        else         drop_q <= drop_d;
    end

    assign symbols_o   = sym_q;
    assign run_o       = run_q;
    assign mon_reset_o = mon_reset_q;
    assign drop_cnt_o  = drop_q;
    assign busy_o      = busy_q;

endmodule

// File: tb/tb_ltl_symbol_encoder.sv
// tb/tb_ltl_symbol_encoder.sv - self-checking bench for ltl_symbol_encoder
module tb_ltl_symbol_encoder;

    localparam int NP  = 3;
    localparam int DEP = 4;
    localparam int RA  = 2;
    localparam int RB  = 12;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Instance a: backpressure mode. Instance b: drop mode, 4-bit counter.
    logic          a_flush = 0, a_valid = 0;
    logic [NP-1:0] a_prop = '0;
    logic          a_ready, a_run, a_mrst, a_busy;
    logic [7:0]    a_sym;
    logic [15:0]   a_drop;

    logic          b_flush = 0, b_valid = 0;
    logic [NP-1:0] b_prop = '0;
    logic          b_ready, b_run, b_mrst, b_busy;
    logic [7:0]    b_sym;
    logic [3:0]    b_drop;

    ltl_symbol_encoder #(.NPROP(NP), .DEPTH(DEP), .RST_CYCLES(RA), .DROP_ON_FULL(0), .DROP_W(16)) dut_a (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(a_flush), .prop_valid_i(a_valid), .prop_i(a_prop),
        .prop_ready_o(a_ready), .symbols_o(a_sym), .run_o(a_run), .mon_reset_o(a_mrst),
        .drop_cnt_o(a_drop), .busy_o(a_busy));

    ltl_symbol_encoder #(.NPROP(NP), .DEPTH(DEP), .RST_CYCLES(RB), .DROP_ON_FULL(1), .DROP_W(4)) dut_b (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(b_flush), .prop_valid_i(b_valid), .prop_i(b_prop),
        .prop_ready_o(b_ready), .symbols_o(b_sym), .run_o(b_run), .mon_reset_o(b_mrst),
        .drop_cnt_o(b_drop), .busy_o(b_busy));

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: a queue of pending symbols, a count of remaining
    // monitor-reset cycles, and the last delivered symbol, per instance.
    int         rst_left [2];
    int         qlen     [2];
    int         qhd      [2];
    int         drops    [2];
    logic [7:0] qbuf     [2][16];
    logic       mrun     [2];
    logic [7:0] msym     [2];
    int         RSTC     [2] = '{RA, RB};
    bit         DOF      [2] = '{1'b0, 1'b1};
    int         DMAX     [2] = '{65535, 15};

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            rst_left[i] = RSTC[i];
            qlen[i] = 0; qhd[i] = 0; drops[i] = 0;
            mrun[i] = 1'b0; msym[i] = 8'h00;
        end
    endtask

    task automatic model_edge(input int i, input bit fl, input bit v, input logic [NP-1:0] p);
        bit inrst, full;
        logic [7:0] s;
        s = 8'(p);
        if (fl) begin
            qlen[i] = 0; mrun[i] = 1'b0; rst_left[i] = RSTC[i];
            if (DOF[i] && v && drops[i] < DMAX[i]) drops[i]++;
        end else begin
            inrst = rst_left[i] > 0;
            full  = qlen[i] == DEP;
            if (!inrst && qlen[i] > 0) begin
                msym[i] = qbuf[i][qhd[i]];
                qhd[i]  = (qhd[i] + 1) % 16;
                qlen[i]--;
                mrun[i] = 1'b1;
            end else begin
                mrun[i] = 1'b0;
            end
            if (v) begin
                if (!inrst && !full) begin
                    qbuf[i][(qhd[i] + qlen[i]) % 16] = s;
                    qlen[i]++;
                end else if (DOF[i] && drops[i] < DMAX[i]) begin
                    drops[i]++;
                end
            end
            if (inrst) rst_left[i]--;
        end
    endtask

    function automatic bit exp_ready(input int i);
        return DOF[i] ? 1'b1 : (rst_left[i] == 0 && qlen[i] < DEP);
    endfunction

    // Inputs are set at the falling edge; model and DUT both take them at
    // the rising edge; outputs are sampled at the following falling edge.
    task automatic tick();
        @(posedge clk);
        model_edge(0, a_flush, a_valid, a_prop);
        model_edge(1, b_flush, b_valid, b_prop);
        @(negedge clk);
    endtask

    task automatic test_reset();
        int hi_cycles;
        rst_n = 1'b0;
        @(negedge clk); @(negedge clk);
        model_reset();
        n_checks++; if (a_mrst !== 1'b1) begin n_fail++; $display("FAIL reset_mon_reset got=%b exp=1", a_mrst); end
        n_checks++; if (a_run !== 1'b0) begin n_fail++; $display("FAIL reset_run got=%b exp=0", a_run); end
        n_checks++; if (a_sym !== 8'h00) begin n_fail++; $display("FAIL reset_symbols got=%h exp=00", a_sym); end
        n_checks++; if (a_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready got=%b exp=0", a_ready); end
        n_checks++; if (a_drop !== 16'h0) begin n_fail++; $display("FAIL reset_drop got=%h exp=0", a_drop); end
        n_checks++; if (a_busy !== 1'b1) begin n_fail++; $display("FAIL reset_busy got=%b exp=1", a_busy); end
        n_checks++; if (b_drop !== 4'h0) begin n_fail++; $display("FAIL reset_drop_b got=%h exp=0", b_drop); end
        rst_n = 1'b1;
        hi_cycles = 0;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (a_mrst === 1'b1) hi_cycles++;
            n_checks++; if (a_run !== 1'b0) begin n_fail++; $display("FAIL rel_run c=%0d got=%b exp=0", c, a_run); end
            n_checks++; if (a_ready !== exp_ready(0)) begin n_fail++; $display("FAIL rel_ready c=%0d got=%b exp=%b", c, a_ready, exp_ready(0)); end
            n_checks++; if (a_ready !== !a_mrst) begin n_fail++; $display("FAIL rel_ready_vs_mrst c=%0d ready=%b mrst=%b", c, a_ready, a_mrst); end
        end
        // Released before the first edge: high through RA edges means RA-1
        // post-edge samples still high.
        n_checks++; if (hi_cycles != RA - 1) begin n_fail++; $display("FAIL rel_mrst_len got=%0d exp=%0d", hi_cycles, RA - 1); end
        n_checks++; if (a_busy !== 1'b0) begin n_fail++; $display("FAIL rel_busy got=%b exp=0", a_busy); end
    endtask

    task automatic test_latency();
        a_valid = 1'b1; a_prop = 3'b101;
        tick();                   // edge closing cycle N
        a_valid = 1'b0; a_prop = '0;
        n_checks++; if (a_run !== 1'b0) begin n_fail++; $display("FAIL lat_n1_run got=%b exp=0", a_run); end
        tick();                   // now in cycle N+2
        n_checks++; if (a_run !== 1'b1) begin n_fail++; $display("FAIL lat_n2_run got=%b exp=1", a_run); end
        n_checks++; if (a_sym !== 8'h05) begin n_fail++; $display("FAIL lat_n2_sym got=%h exp=05", a_sym); end
        tick();
        n_checks++; if (a_run !== 1'b0) begin n_fail++; $display("FAIL lat_n3_run got=%b exp=0", a_run); end
        n_checks++; if (a_sym !== 8'h05) begin n_fail++; $display("FAIL lat_n3_hold got=%h exp=05", a_sym); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_q[$];
        for (int c = 0; c < 16; c++) begin
            if (c < 6) begin
                a_valid = 1'b1;
                a_prop  = NP'($urandom_range(0, 7));
                exp_q.push_back(8'(a_prop));
            end else begin
                a_valid = 1'b0;
            end
            n_checks++; if (a_ready !== exp_ready(0)) begin n_fail++; $display("FAIL b2b_ready c=%0d got=%b exp=%b", c, a_ready, exp_ready(0)); end
            tick();
            n_checks++; if (a_run !== mrun[0]) begin n_fail++; $display("FAIL b2b_run c=%0d got=%b exp=%b", c, a_run, mrun[0]); end
            if (a_run === 1'b1) begin
                n_checks++;
                if (exp_q.size() == 0) begin n_fail++; $display("FAIL b2b_extra got=%h exp=none", a_sym); end
                else if (a_sym !== exp_q[0]) begin n_fail++; $display("FAIL b2b_order got=%h exp=%h", a_sym, exp_q[0]); void'(exp_q.pop_front()); end
                else void'(exp_q.pop_front());
            end
        end
        n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL b2b_delivered left=%0d exp=0", exp_q.size()); end
        n_checks++; if (a_drop !== 16'h0) begin n_fail++; $display("FAIL b2b_drop got=%h exp=0", a_drop); end
    endtask

    task automatic test_drop_mode();
        logic [7:0] exp_q[$];
        int guard;
        b_flush = 1'b1; b_valid = 1'b0;
        tick();
        b_flush = 1'b0;
        for (int c = 0; c < 10; c++) begin
            b_valid = 1'b1; b_prop = NP'($urandom_range(0, 7));
            tick();
            n_checks++; if (b_run !== 1'b0) begin n_fail++; $display("FAIL drop_rst_run c=%0d got=%b exp=0", c, b_run); end
        end
        b_valid = 1'b0;
        n_checks++; if (b_drop !== 4'd10) begin n_fail++; $display("FAIL drop_in_rst got=%0d exp=10", b_drop); end
        guard = 0;
        while (rst_left[1] > 0 && guard < 20) begin tick(); guard++; end
        tick();
        n_checks++; if (b_mrst !== 1'b0) begin n_fail++; $display("FAIL drop_mrst_fall got=%b exp=0", b_mrst); end
        for (int c = 0; c < 20; c++) begin
            if (c < 12) begin
                b_valid = 1'b1; b_prop = NP'($urandom_range(0, 7));
                if (qlen[1] < DEP) exp_q.push_back(8'(b_prop));
            end else begin
                b_valid = 1'b0;
            end
            tick();
            if (b_run === 1'b1) begin
                n_checks++;
                if (exp_q.size() == 0) begin n_fail++; $display("FAIL drop_extra got=%h exp=none", b_sym); end
                else if (b_sym !== exp_q[0]) begin n_fail++; $display("FAIL drop_order got=%h exp=%h", b_sym, exp_q[0]); void'(exp_q.pop_front()); end
                else void'(exp_q.pop_front());
            end
        end
        b_valid = 1'b0;
        n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL drop_delivered left=%0d exp=0", exp_q.size()); end
        n_checks++; if (b_drop !== 4'(drops[1])) begin n_fail++; $display("FAIL drop_total got=%0d exp=%0d", b_drop, drops[1]); end
    endtask

    task automatic test_flush();
        int hi;
        logic [7:0] killed[2];
        for (int c = 0; c < 3; c++) begin
            a_valid = 1'b1; a_prop = NP'(c + 5);
            if (c >= 1) killed[c-1] = 8'(a_prop);
            a_flush = (c == 2);
            tick();
        end
        a_valid = 1'b0; a_flush = 1'b0;
        n_checks++; if (a_run !== 1'b0) begin n_fail++; $display("FAIL flush_run got=%b exp=0", a_run); end
        n_checks++; if (a_mrst !== 1'b1) begin n_fail++; $display("FAIL flush_mrst got=%b exp=1", a_mrst); end
        hi = 1;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (a_mrst === 1'b1) hi++;
            n_checks++; if (a_run !== 1'b0) begin n_fail++; $display("FAIL flush_killed_run c=%0d got=%b sym=%h never_emit=%h,%h", c, a_run, a_sym, killed[0], killed[1]); end
        end
        n_checks++; if (hi != RA) begin n_fail++; $display("FAIL flush_mrst_len got=%0d exp=%0d", hi, RA); end
        n_checks++; if (a_busy !== 1'b0) begin n_fail++; $display("FAIL flush_busy got=%b exp=0", a_busy); end
    endtask

    task automatic test_saturate();
        b_flush = 1'b1; b_valid = 1'b1;
        for (int c = 0; c < 20; c++) tick();
        b_flush = 1'b0; b_valid = 1'b0;
        tick();
        n_checks++; if (b_drop !== 4'hF) begin n_fail++; $display("FAIL sat_value got=%h exp=F", b_drop); end
        b_flush = 1'b1; tick(); b_flush = 1'b0; tick();
        n_checks++; if (b_drop !== 4'hF) begin n_fail++; $display("FAIL sat_after_flush got=%h exp=F", b_drop); end
        rst_n = 1'b0;
        #1;
        model_reset();
        n_checks++; if (b_drop !== 4'h0) begin n_fail++; $display("FAIL sat_after_rst got=%h exp=0", b_drop); end
        n_checks++; if (b_mrst !== 1'b1) begin n_fail++; $display("FAIL sat_rst_mrst got=%b exp=1", b_mrst); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            a_flush = ($urandom_range(0, 19) == 0);
            b_flush = ($urandom_range(0, 19) == 0);
            a_valid = ($urandom_range(0, 9) < 7);
            b_valid = ($urandom_range(0, 9) < 7);
            a_prop  = NP'($urandom);
            b_prop  = NP'($urandom);
            n_checks++; if (a_ready !== exp_ready(0)) begin n_fail++; $display("FAIL rnd_a_ready c=%0d got=%b exp=%b", c, a_ready, exp_ready(0)); end
            n_checks++; if (b_ready !== exp_ready(1)) begin n_fail++; $display("FAIL rnd_b_ready c=%0d got=%b exp=%b", c, b_ready, exp_ready(1)); end
            tick();
            n_checks++; if (a_run !== mrun[0] || a_sym !== msym[0]) begin n_fail++; $display("FAIL rnd_a_out c=%0d run=%b sym=%h exp run=%b sym=%h", c, a_run, a_sym, mrun[0], msym[0]); end
            n_checks++; if (b_run !== mrun[1] || b_sym !== msym[1]) begin n_fail++; $display("FAIL rnd_b_out c=%0d run=%b sym=%h exp run=%b sym=%h", c, b_run, b_sym, mrun[1], msym[1]); end
            n_checks++; if (a_mrst !== (rst_left[0] > 0) || b_mrst !== (rst_left[1] > 0)) begin n_fail++; $display("FAIL rnd_mrst c=%0d a=%b b=%b exp a=%0d b=%0d", c, a_mrst, b_mrst, rst_left[0] > 0, rst_left[1] > 0); end
            n_checks++; if (a_busy !== (qlen[0] > 0 || rst_left[0] > 0) || b_busy !== (qlen[1] > 0 || rst_left[1] > 0)) begin n_fail++; $display("FAIL rnd_busy c=%0d a=%b b=%b", c, a_busy, b_busy); end
            n_checks++; if (a_drop !== 16'(drops[0]) || b_drop !== 4'(drops[1])) begin n_fail++; $display("FAIL rnd_drop c=%0d a=%0d b=%0d exp a=%0d b=%0d", c, a_drop, b_drop, drops[0], drops[1]); end
            n_checks++; if ((a_run && a_mrst) || (b_run && b_mrst)) begin n_fail++; $display("FAIL rnd_run_in_reset c=%0d a=%b%b b=%b%b exp no overlap", c, a_run, a_mrst, b_run, b_mrst); end
        end
        a_flush = 1'b0; b_flush = 1'b0; a_valid = 1'b0; b_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_latency();
        test_back_to_back();
        test_drop_mode();
        test_flush();
        test_saturate();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
